// File: rtl/csr_lhs_packer.sv
// Row-major dense-to-CSR encoder feeding the SpMM lhs port.
// Nonzeros are compacted into N-slot batches; overflowing matrices continue in output-stationary batches.
module csr_lhs_packer #(
  parameter  int unsigned N       = 16,
  parameter  int unsigned W       = 8,
  localparam int unsigned LG_N    = (N > 1) ? $clog2(N) : 1,
  localparam int unsigned DB_LG_N = 2 * LG_N,
  localparam int unsigned CNT_W   = LG_N + 1
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               in_valid,
  input  logic [W-1:0]       in_data,
  output logic               in_ready,
  input  logic               cfg_ws,
  input  logic               lhs_ready_ns,
  input  logic               lhs_ready_ws,
  input  logic               lhs_ready_os,
  input  logic               lhs_ready_wos,
  output logic               lhs_start,
  output logic               lhs_ws,
  output logic               lhs_os,
  output logic [DB_LG_N-1:0] lhs_ptr  [N],
  output logic [LG_N-1:0]    lhs_col  [N],
  output logic [W-1:0]       lhs_data [N],
  output logic               mat_done,
  output logic [31:0]        num_el
);

  typedef enum logic {
    S_FILL = 1'b0,
    S_SEND = 1'b1
  } state_e;

  state_e               state_q, state_d;
  logic [LG_N-1:0]      row_q, row_d;
  logic [LG_N-1:0]      col_q, col_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [DB_LG_N-1:0]   ptr_q [N];
  logic [DB_LG_N-1:0]   ptr_d [N];
  logic [LG_N-1:0]      slot_col_q [N];
  logic [LG_N-1:0]      slot_col_d [N];
  logic [W-1:0]         slot_data_q [N];
  logic [W-1:0]         slot_data_d [N];
  logic                 ws_q, ws_d;
  logic                 os_q, os_d;
  logic                 final_q, final_d;
  logic                 sel_ready_c;
  logic                 last_el_c;

  // Only the ready line matching the current batch mode can release it.
  always_comb begin
    sel_ready_c = 1'b0;
    unique case ({ws_q, os_q})
      2'b00: sel_ready_c = lhs_ready_ns;
      2'b10: sel_ready_c = lhs_ready_ws;
      2'b01: sel_ready_c = lhs_ready_os;
      2'b11: sel_ready_c = lhs_ready_wos;
      default: sel_ready_c = 1'b0;
    endcase
  end

  assign last_el_c = (row_q == LG_N'(N - 1)) && (col_q == LG_N'(N - 1));

  always_comb begin
    state_d     = state_q;
    row_d       = row_q;
    col_d       = col_q;
    cnt_d       = cnt_q;
    ptr_d       = ptr_q;
    slot_col_d  = slot_col_q;
    slot_data_d = slot_data_q;
    ws_d        = ws_q;
    os_d        = os_q;
    final_d     = final_q;
    in_ready    = 1'b0;
    lhs_start   = 1'b0;
    mat_done    = 1'b0;

    unique case (state_q)
      S_FILL: begin
        in_ready = !reset;
        if (in_valid && !reset) begin
          if ((row_q == '0) && (col_q == '0)) ws_d = cfg_ws;
          if (in_data != '0) begin
            slot_col_d[cnt_q[LG_N-1:0]]  = col_q;
            slot_data_d[cnt_q[LG_N-1:0]] = in_data;
            cnt_d = cnt_q + CNT_W'(1);
          end
          if (col_q == LG_N'(N - 1)) begin
            ptr_d[row_q] = DB_LG_N'(cnt_d);
            col_d = '0;
            row_d = (row_q == LG_N'(N - 1)) ? '0 : row_q + LG_N'(1);
          end else begin
            col_d = col_q + LG_N'(1);
          end
          if (last_el_c) begin
            final_d = 1'b1;
            state_d = S_SEND;
          end else if (cnt_d == CNT_W'(N)) begin
            // Rows still open at an overflow flush end at the batch fill level.
            final_d = 1'b0;
            state_d = S_SEND;
            for (int unsigned i = 0; i < N; i++) begin
              if (LG_N'(i) >= row_d) ptr_d[i] = DB_LG_N'(cnt_d);
            end
          end
        end
      end
      S_SEND: begin
        lhs_start = sel_ready_c;
        mat_done  = sel_ready_c & final_q;
        if (sel_ready_c) begin
          state_d = S_FILL;
          cnt_d   = '0;
          final_d = 1'b0;
          for (int unsigned i = 0; i < N; i++) begin
            ptr_d[i]       = '0;
            slot_col_d[i]  = '0;
            slot_data_d[i] = '0;
          end
          if (final_q) begin
            row_d = '0;
            col_d = '0;
            os_d  = 1'b0;
          end else begin
            os_d  = 1'b1;
          end
        end
      end
      default: state_d = S_FILL;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_FILL;
      row_q   <= '0;
      col_q   <= '0;
      cnt_q   <= '0;
      ws_q    <= 1'b0;
      os_q    <= 1'b0;
      final_q <= 1'b0;
      for (int unsigned i = 0; i < N; i++) begin
        ptr_q[i]       <= '0;
        slot_col_q[i]  <= '0;
        slot_data_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      row_q       <= row_d;
      col_q       <= col_d;
      cnt_q       <= cnt_d;
      ws_q        <= ws_d;
      os_q        <= os_d;
      final_q     <= final_d;
      ptr_q       <= ptr_d;
      slot_col_q  <= slot_col_d;
      slot_data_q <= slot_data_d;
    end
  end

  assign lhs_ws   = ws_q;
  assign lhs_os   = os_q;
  assign lhs_ptr  = ptr_q;
  assign lhs_col  = slot_col_q;
  assign lhs_data = slot_data_q;
  assign num_el   = 32'(N);

endmodule

// File: tb/tb_csr_lhs_packer.sv
// Bench for csr_lhs_packer (N=4): random and directed matrices checked against a batch-list model.
module tb_csr_lhs_packer;
  localparam int unsigned N    = 4;
  localparam int unsigned W    = 8;
  localparam int unsigned LG   = 2;
  localparam int unsigned DB   = 4;
  localparam int          NN   = 16;
  localparam int          MAXB = 8;

  logic          clock = 1'b0;
  logic          reset;
  logic          in_valid;
  logic [W-1:0]  in_data;
  logic          in_ready;
  logic          cfg_ws;
  logic          lhs_ready_ns, lhs_ready_ws, lhs_ready_os, lhs_ready_wos;
  logic          lhs_start, lhs_ws, lhs_os, mat_done;
  logic [DB-1:0] lhs_ptr  [N];
  logic [LG-1:0] lhs_col  [N];
  logic [W-1:0]  lhs_data [N];
  logic [31:0]   num_el;

  int n_checks = 0;
  int n_fail   = 0;
  int n_start  = 0;

  int cur_mat [NN];
  int m_nb;
  int m_ptr [MAXB][N];
  int m_col [MAXB][N];
  int m_dat [MAXB][N];
  bit m_fin [MAXB];
  int m_end [MAXB];

  csr_lhs_packer #(.N(N), .W(W)) dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .cfg_ws(cfg_ws),
    .lhs_ready_ns(lhs_ready_ns), .lhs_ready_ws(lhs_ready_ws),
    .lhs_ready_os(lhs_ready_os), .lhs_ready_wos(lhs_ready_wos),
    .lhs_start(lhs_start), .lhs_ws(lhs_ws), .lhs_os(lhs_os),
    .lhs_ptr(lhs_ptr), .lhs_col(lhs_col), .lhs_data(lhs_data),
    .mat_done(mat_done), .num_el(num_el)
  );

  always #5 clock = ~clock;

  // Splits the nonzero list into batches; a row finished before a batch starts reads 0.
  task automatic build_model();
    int k, s, c;
    int rows [N];
    int cols [N];
    int vals [N];
    k = 0; s = 0; m_nb = 0;
    for (int e = 0; e < NN; e++) begin
      if (cur_mat[e] != 0) begin
        rows[k] = e / N; cols[k] = e % N; vals[k] = cur_mat[e]; k++;
      end
      if (e == NN - 1 || k == int'(N)) begin
        for (int r = 0; r < int'(N); r++) begin
          c = 0;
          for (int j = 0; j < k; j++) if (rows[j] <= r) c++;
          m_ptr[m_nb][r] = (r * int'(N) + int'(N) - 1 < s) ? 0 : c;
        end
        for (int j = 0; j < int'(N); j++) begin
          m_col[m_nb][j] = (j < k) ? cols[j] : 0;
          m_dat[m_nb][j] = (j < k) ? vals[j] : 0;
        end
        m_fin[m_nb] = (e == NN - 1);
        m_end[m_nb] = e;
        m_nb++;
        k = 0;
        s = e + 1;
      end
    end
  endtask

  task automatic run_matrix(input bit ws, input int hold, input bit gaps, input bit ns_stuck);
    int e, b, w, cyc, hold_now, idx;
    bit exp_send, sel, valid, os_b;
    logic [3:0] rdy;
    build_model();
    e = 0; b = 0; w = 0; cyc = 0; exp_send = 1'b0;
    hold_now = (hold < 0) ? int'($urandom_range(3, 0)) : hold;
    while (b < m_nb) begin
      @(negedge clock);
      cyc++;
      if (cyc > 400) begin
        n_checks++; n_fail++;
        $display("FAIL timeout: batch %0d of %0d not handed off within 400 cycles", b, m_nb);
        break;
      end
      os_b  = (b > 0);
      idx   = (ws ? 2 : 0) + (os_b ? 1 : 0);
      rdy   = 4'($urandom);
      valid = 1'b0;
      sel   = 1'b0;
      in_valid = 1'($urandom_range(1, 0));
      in_data  = W'($urandom);
      cfg_ws   = 1'($urandom_range(1, 0));
      if (!exp_send) begin
        valid    = gaps ? ($urandom_range(3, 0) != 0) : 1'b1;
        in_valid = valid;
        in_data  = W'(cur_mat[e]);
        if (e == 0) cfg_ws = ws;
      end else begin
        sel = (w >= hold_now);
        rdy[idx] = sel;
      end
      if (ns_stuck) rdy[0] = 1'b1;
      lhs_ready_ns = rdy[0]; lhs_ready_os = rdy[1];
      lhs_ready_ws = rdy[2]; lhs_ready_wos = rdy[3];
      #1;
      n_checks++;
      if (in_ready !== !exp_send) begin
        n_fail++;
        $display("FAIL in_ready: elem %0d batch %0d got %b want %b", e, b, in_ready, !exp_send);
      end
      if (lhs_start === 1'b1) n_start++;
      if (!exp_send) begin
        n_checks++;
        if (lhs_start !== 1'b0 || mat_done !== 1'b0) begin
          n_fail++;
          $display("FAIL start_in_fill: elem %0d got start=%b done=%b want 0", e, lhs_start, mat_done);
        end
        if (valid) begin
          if (e == m_end[b]) exp_send = 1'b1;
          e++;
        end
      end else begin
        n_checks++;
        if (lhs_start !== sel || mat_done !== (sel & m_fin[b])) begin
          n_fail++;
          $display("FAIL handoff: batch %0d wait %0d got start=%b done=%b want start=%b done=%b",
                   b, w, lhs_start, mat_done, sel, sel & m_fin[b]);
        end
        n_checks++;
        if (lhs_ws !== ws || lhs_os !== os_b) begin
          n_fail++;
          $display("FAIL mode: batch %0d got ws=%b os=%b want ws=%b os=%b", b, lhs_ws, lhs_os, ws, os_b);
        end
        for (int i = 0; i < int'(N); i++) begin
          n_checks++;
          if (lhs_ptr[i] !== DB'(m_ptr[b][i]) || lhs_col[i] !== LG'(m_col[b][i]) ||
              lhs_data[i] !== W'(m_dat[b][i])) begin
            n_fail++;
            $display("FAIL slot%0d: batch %0d got ptr=%0d col=%0d data=%0d want ptr=%0d col=%0d data=%0d",
                     i, b, lhs_ptr[i], lhs_col[i], lhs_data[i], m_ptr[b][i], m_col[b][i], m_dat[b][i]);
          end
        end
        if (sel) begin
          b++; w = 0; exp_send = 1'b0;
          hold_now = (hold < 0) ? int'($urandom_range(3, 0)) : hold;
        end else begin
          w++;
        end
      end
    end
    @(negedge clock);
    in_valid = 1'b0;
    lhs_ready_ns = 1'b0; lhs_ready_ws = 1'b0; lhs_ready_os = 1'b0; lhs_ready_wos = 1'b0;
  endtask

  task automatic load_overflow();
    for (int e = 0; e < NN; e++) cur_mat[e] = 0;
    cur_mat[0] = 1; cur_mat[1] = 2; cur_mat[2] = 3; cur_mat[3] = 4; cur_mat[4] = 5;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clock);
    #1;
    n_checks++;
    if (in_ready !== 1'b0 || lhs_start !== 1'b0 || mat_done !== 1'b0 || lhs_ws !== 1'b0 || lhs_os !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: got ready=%b start=%b done=%b ws=%b os=%b want all 0",
               in_ready, lhs_start, mat_done, lhs_ws, lhs_os);
    end
    for (int i = 0; i < int'(N); i++) begin
      n_checks++;
      if (lhs_ptr[i] !== '0 || lhs_col[i] !== '0 || lhs_data[i] !== '0) begin
        n_fail++;
        $display("FAIL reset_slot%0d: got ptr=%0d col=%0d data=%0d want 0", i, lhs_ptr[i], lhs_col[i], lhs_data[i]);
      end
    end
    n_checks++;
    if (num_el !== 32'(N)) begin
      n_fail++;
      $display("FAIL num_el: got %0d want %0d", num_el, N);
    end
    reset = 1'b0;
  endtask

  task automatic test_single_diagonal();
    int s0;
    for (int e = 0; e < NN; e++) cur_mat[e] = 0;
    cur_mat[0] = 1; cur_mat[5] = 2; cur_mat[10] = 3; cur_mat[15] = 4;
    s0 = n_start;
    run_matrix(1'b0, 0, 1'b0, 1'b0);
    n_checks++;
    if (n_start - s0 !== 1) begin
      n_fail++;
      $display("FAIL diag_batches: got %0d starts want 1", n_start - s0);
    end
  endtask

  task automatic test_all_zero();
    int s0;
    for (int e = 0; e < NN; e++) cur_mat[e] = 0;
    s0 = n_start;
    run_matrix(1'b0, -1, 1'b1, 1'b0);
    n_checks++;
    if (n_start - s0 !== 1) begin
      n_fail++;
      $display("FAIL zero_batches: got %0d starts want 1", n_start - s0);
    end
  endtask

  task automatic test_overflow_split();
    int s0;
    load_overflow();
    s0 = n_start;
    run_matrix(1'b0, 0, 1'b0, 1'b0);
    n_checks++;
    if (n_start - s0 !== 2) begin
      n_fail++;
      $display("FAIL split_batches: got %0d starts want 2", n_start - s0);
    end
  endtask

  task automatic test_backpressure();
    int s0;
    load_overflow();
    s0 = n_start;
    run_matrix(1'b0, 5, 1'b0, 1'b0);
    n_checks++;
    if (n_start - s0 !== 2) begin
      n_fail++;
      $display("FAIL bp_pulses: got %0d starts want 2", n_start - s0);
    end
  endtask

  task automatic test_mode_select();
    load_overflow();
    run_matrix(1'b1, 3, 1'b1, 1'b1);
  endtask

  task automatic test_reset_mid_fill();
    int pre [7];
    pre = '{1, 0, 2, 0, 0, 3, 0};
    for (int i = 0; i < 7; i++) begin
      @(negedge clock);
      in_valid = 1'b1; in_data = W'(pre[i]); cfg_ws = (i == 0);
    end
    @(negedge clock);
    in_valid = 1'b0;
    reset = 1'b1;
    repeat (2) @(negedge clock);
    #1;
    n_checks++;
    if (in_ready !== 1'b0 || lhs_ws !== 1'b0 || lhs_os !== 1'b0 || lhs_start !== 1'b0) begin
      n_fail++;
      $display("FAIL midfill_ctrl: got ready=%b ws=%b os=%b start=%b want all 0",
               in_ready, lhs_ws, lhs_os, lhs_start);
    end
    for (int i = 0; i < int'(N); i++) begin
      n_checks++;
      if (lhs_ptr[i] !== '0 || lhs_col[i] !== '0 || lhs_data[i] !== '0) begin
        n_fail++;
        $display("FAIL midfill_slot%0d: got ptr=%0d col=%0d data=%0d want 0", i, lhs_ptr[i], lhs_col[i], lhs_data[i]);
      end
    end
    reset = 1'b0;
    for (int e = 0; e < NN; e++) cur_mat[e] = 0;
    cur_mat[0] = 9; cur_mat[6] = 7; cur_mat[15] = 6;
    run_matrix(1'b1, -1, 1'b1, 1'b0);
  endtask

  task automatic test_random();
    int dens;
    for (int m = 0; m < 16; m++) begin
      dens = (m % 4 == 0) ? 100 : int'($urandom_range(70, 5));
      for (int e = 0; e < NN; e++)
        cur_mat[e] = ($urandom_range(99, 0) < dens) ? int'($urandom_range(255, 1)) : 0;
      run_matrix(1'($urandom_range(1, 0)), -1, 1'b1, 1'b0);
    end
  endtask

  initial begin
    reset = 1'b1;
    in_valid = 1'b0; in_data = '0; cfg_ws = 1'b0;
    lhs_ready_ns = 1'b0; lhs_ready_ws = 1'b0; lhs_ready_os = 1'b0; lhs_ready_wos = 1'b0;
    test_reset();
    test_single_diagonal();
    test_all_zero();
    test_overflow_split();
    test_backpressure();
    test_mode_select();
    test_reset_mid_fill();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/csr_lhs_packer.md
# csr_lhs_packer

Row-major dense-to-CSR encoder that drives the lhs port of the SpMM engine. It accepts an N×N dense matrix one element per cycle and compacts the nonzeros into N-slot batches (`lhs_ptr`/`lhs_col`/`lhs_data`). It hands each batch to SpMM through the lhs ready/start handshake. When a matrix holds more than N nonzeros, the block splits it into several batches and flags every continuation batch output-stationary, so SpMM accumulates the partial results.

## Interface
- `N`, default 16: matrix dimension and slots per batch; lgN = clog2(N), dbLgN = 2·lgN.
- `W`, default 8: element width (`data_t`).

Ports:
- `clock`  in  1  sole clock.
- `reset`  in  1  synchronous, active-high.
- `in_valid`  in  1  element valid.
- `in_data`  in  data_t  element value, row-major order.
- `in_ready`  out  1  element accepted on an edge with `in_valid`&`in_ready`.
- `cfg_ws`  in  1  weight-stationary request, sampled with element (0,0).
- `lhs_ready_ns`, `lhs_ready_ws`, `lhs_ready_os`, `lhs_ready_wos`  in  1 each  SpMM readiness per mode.
- `lhs_start`  out  1  one-cycle handoff strobe.
- `lhs_ws`, `lhs_os`  out  1 each  mode of the current batch.
- `lhs_ptr[N]`  out  dbLgN each  exclusive end index of row i within the batch.
- `lhs_col[N]`  out  lgN each  column of slot k.
- `lhs_data[N]`  out  data_t each  value of slot k.
- `mat_done`  out  1  pulses with `lhs_start` of a matrix's final batch.
- `num_el`  out  int  constant N.

## Operation
- Internal counters `row`, `col` (lgN bits each) track the position of the next element, and `cnt` (lgN+1 bits) counts filled slots.
- FSM states:
  - FILL: `in_ready`=1.
  - SEND: `in_ready`=0, batch outputs held stable.
- Accept rules in FILL:
  - If `in_data`≠0: write slot `cnt` with `lhs_col`=`col` and `lhs_data`=`in_data`, then increment `cnt`.
  - Zeros are skipped and never stored.
  - Then `col`++. At `col`=N−1, latch `ptr[row]`=`cnt` (post-increment value), clear `col` and increment `row`.
- FILL→SEND happens on the accepting edge when either condition holds:
  - `cnt` reaches N (overflow flush), or
  - element (N−1,N−1) is accepted (final batch).
- The final case takes priority when both conditions hold.
- `lhs_ptr` output rules:
  - Rows completed in this batch show their latched value.
  - Rows not yet completed show `cnt` at flush.
  - Rows completed in earlier batches show 0.
- Slots ≥ `cnt` drive `lhs_col`=0 and `lhs_data`=0.
- Mode flags:
  - `lhs_ws` = `cfg_ws` sampled at element (0,0). It is constant for all batches of that matrix.
  - `lhs_os` = 0 for the first batch of a matrix and 1 for every continuation batch.
- SEND selects one ready input by {`lhs_ws`,`lhs_os`}: 00→ns, 10→ws, 01→os, 11→wos. The other three ready inputs are ignored.
- `lhs_start` = (state==SEND) & selected ready. This is combinational and is the handoff cycle.
- On the handoff edge:
  - Clear all slots, the ptr registers and `cnt`, then return to FILL.
  - If the batch was final, also clear `row`, `col` and the os flag.
  - If not final, set the os flag and keep `row`/`col`.
- An overflow flush at the exact last nonzero can leave a trailing continuation batch with all ptr=0. That batch is still sent, with `lhs_os`=1.
- Reset overrides everything, including a pending handoff. The block restarts at element (0,0) in FILL.

## Timing
- All outputs reset to 0 while `reset` is high, and `in_ready` is 0 during reset.
- Batch outputs are registered. They are valid from the cycle after the flushing accept through the handoff cycle inclusive.
- Fastest batch: flushing accept at edge t, SEND from t+1. With ready high at t+1, `lhs_start`=1 at t+1 and `in_ready`=1 again at t+2.
- No element is accepted during SEND; there is no bypass.
- `mat_done` = `lhs_start` & final.
- Throughput is N² accept cycles plus one cycle minimum per batch.

## Test plan
1. **Single diagonal batch.** N=4, diagonal 1,2,3,4 with other elements 0, ready_ns=1 → one batch with ptr={1,2,3,4}, col={0,1,2,3}, data={1,2,3,4}, os=0, ws=0; `lhs_start` and `mat_done` high together one cycle after the 16th accept.
2. **All-zero matrix.** N=4, all elements 0 → one batch with ptr={0,0,0,0}, all slots 0, `mat_done`=1.
3. **Overflow split.** N=4, row0={1,2,3,4}, row1={5,0,0,0}, rest 0:
   - Batch0 flushes after the 4th accept with ptr={4,4,4,4}, col={0,1,2,3}, os=0.
   - Batch1 has ptr={0,1,1,1}, col[0]=0, data[0]=5, os=1, `mat_done`=1.
4. **Backpressure.** Hold the selected ready low for 5 cycles in SEND → `in_ready`=0 and outputs bit-stable throughout; `lhs_start` is a single pulse on the first ready cycle.
5. **Mode select.** `cfg_ws`=1 at (0,0) with the overflow stimulus from test 3, and ready_ns stuck high → batch0 waits on ready_ws and batch1 waits on ready_wos; ready_ns has no effect.
6. **Reset mid-fill.** Assert reset after 7 accepts (3 nonzeros) → all outputs 0; the next accepted element lands in slot 0 as (0,0), and the ptr values reflect only post-reset data.
